// File: rtl/buff_pkg.sv
// Shared types and sizing helpers for the byte-serializer scheduler.
// Holds the state enum, frame-length helpers and the parameter sanity check.
package buff_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    function automatic int count_of(input int data_bits, input int bits);
        return data_bits / bits;
    endfunction

    // Counter must reach COUNT during the post-reset drain window.
    function automatic int cnt_width(input int count);
        return $clog2(count + 2);
    endfunction

    function automatic bit cfg_ok(input int nreq, input int data_bits, input int bits);
        return (nreq >= 2) && (bits == 8) && ((data_bits % bits) == 0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer and wraps.
// Produces a one-hot grant and its encoded index; all zero when disabled or idle.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic found_s;
    int   cand_s;

    // First requester after the pointer (modulo NREQ) wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = (int'(ptr) + k) % NREQ;
            if (en && !found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = IW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/buff_sched.sv
// Round-robin scheduler sharing one byte serializer between NREQ requesters,
// with frame sideband registered to line up with the serializer's byte output.
module buff_sched
    import buff_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8,
    parameter int SRCW      = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_BITS-1:0] data_in,
    output logic [NREQ-1:0]           ack,
    output logic                      ser_start,
    output logic [DATA_BITS-1:0]      ser_data,
    output logic                      byte_valid,
    output logic                      byte_first,
    output logic                      byte_last,
    output logic [SRCW-1:0]           byte_src,
    output logic                      busy
);

    localparam int COUNT = count_of(DATA_BITS, BITS);
    localparam int CW    = cnt_width(COUNT);

    if (!cfg_ok(NREQ, DATA_BITS, BITS)) begin : g_cfg_err
        $error("buff_sched: NREQ must be >= 2, BITS 8, DATA_BITS a multiple of BITS");
    end

    state_t          state_r, state_nxt;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    logic [SRCW-1:0] ptr_r;
    logic            arb_en_s;
    logic [NREQ-1:0] gnt_s;
    logic [SRCW-1:0] gnt_idx_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (SRCW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_r),
        .en    (arb_en_s),
        .grant (gnt_s),
        .idx   (gnt_idx_s)
    );

    // Next-state and counter logic; arbitration only in IDLE or the final STREAM byte.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        arb_en_s  = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                if (cnt_r == CW'(COUNT)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_r + CW'(1);
                end
            end
            ST_IDLE: begin
                if (en && (|req)) begin
                    arb_en_s  = 1'b1;
                    state_nxt = ST_LAUNCH;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_STREAM;
                cnt_nxt   = '0;
            end
            ST_STREAM: begin
                if (cnt_r == CW'(COUNT - 1)) begin
                    cnt_nxt = '0;
                    if (en && (|req)) begin
                        arb_en_s  = 1'b1;
                        state_nxt = ST_LAUNCH;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FLUSH;
            cnt_r   <= '0;
            ptr_r   <= SRCW'(NREQ - 1);
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            if (arb_en_s) begin
                ptr_r <= gnt_idx_s;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= '0;
            ser_start  <= 1'b0;
            ser_data   <= '0;
            byte_valid <= 1'b0;
            byte_first <= 1'b0;
            byte_last  <= 1'b0;
            byte_src   <= '0;
            busy       <= 1'b0;
        end else begin
            ack        <= arb_en_s ? gnt_s : '0;
            ser_start  <= arb_en_s;
            byte_valid <= (state_nxt == ST_STREAM);
            byte_first <= (state_nxt == ST_STREAM) && (cnt_nxt == '0);
            byte_last  <= (state_nxt == ST_STREAM) && (cnt_nxt == CW'(COUNT - 1));
            busy       <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_STREAM);
            if (arb_en_s) begin
                ser_data <= data_in[int'(gnt_idx_s)*DATA_BITS +: DATA_BITS];
                byte_src <= gnt_idx_s;
            end
        end
    end

endmodule

// File: tb/tb_buff_sched.sv
// Randomized self-checking bench for buff_sched (NREQ=2, DATA_BITS=32, 4-byte frames)
// against a slot-based frame model and a simple serializer model.
module tb_buff_sched;

    localparam int NREQ  = 2;
    localparam int DW    = 32;
    localparam int COUNT = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   data_in = '0;
    logic [NREQ-1:0]      ack;
    logic                 ser_start;
    logic [DW-1:0]        ser_data;
    logic                 byte_valid, byte_first, byte_last, busy;
    logic [0:0]           byte_src;

    int n_checks = 0;
    int n_errors = 0;

    // Model: slot 0 = no frame, 1 = launch, 2..COUNT+1 = stream byte slot-2.
    int          slot, flush_left, ptr, e_src;
    logic [DW-1:0] e_data;
    // Serializer model fed by the scheduler outputs.
    logic [DW-1:0] ser_word;
    int            ser_pos;

    buff_sched #(.NREQ(NREQ), .DATA_BITS(DW), .BITS(8), .SRCW(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_in(data_in),
        .ack(ack), .ser_start(ser_start), .ser_data(ser_data),
        .byte_valid(byte_valid), .byte_first(byte_first), .byte_last(byte_last),
        .byte_src(byte_src), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot = 0; flush_left = 0; ptr = NREQ - 1; e_src = 0; e_data = '0;
        ser_word = '0; ser_pos = -1;
    endtask

    task automatic model_step();
        bit can_arb;
        bit got;
        int w;
        if (flush_left > 0) begin
            flush_left--;
            can_arb = 1'b0;
        end else begin
            can_arb = (slot == 0) || (slot == COUNT + 1);
        end
        if (can_arb && en && (req != '0)) begin
            got = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                w = (ptr + k) % NREQ;
                if (!got && req[w]) begin
                    got = 1'b1;
                    ptr = w;
                end
            end
            e_src  = ptr;
            e_data = data_in[ptr*DW +: DW];
            slot   = 1;
        end else if (slot >= 1 && slot <= COUNT) begin
            slot++;
        end else begin
            slot = 0;
        end
    endtask

    task automatic check_all();
        logic [7:0] sb;
        logic [NREQ-1:0] e_ack;
        e_ack = '0;
        if (slot == 1) e_ack[e_src] = 1'b1;
        check("ack",        ack,        e_ack);
        check("ser_start",  ser_start,  slot == 1);
        check("byte_valid", byte_valid, slot >= 2);
        check("byte_first", byte_first, slot == 2);
        check("byte_last",  byte_last,  slot == COUNT + 1);
        check("busy",       busy,       slot >= 1);
        check("byte_src",   byte_src,   e_src);
        check("ser_data",   ser_data,   e_data);
        sb = (ser_pos >= 0) ? ser_word[DW-1-8*ser_pos -: 8] : 8'hxx;
        if (slot >= 2) check("ser_byte", sb, e_data[DW-1-8*(slot-2) -: 8]);
        if (ser_start) begin
            ser_word = ser_data;
            ser_pos  = 0;
        end else if (ser_pos >= 0) begin
            ser_pos = (ser_pos + 1 >= COUNT) ? -1 : ser_pos + 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, then release on a falling edge.
    task automatic apply_reset(input int ncyc);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (ncyc) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        flush_left = COUNT + 1;
    endtask

    task automatic wait_slot(input int target, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            cycle();
            if (slot == target) hit = 1'b1;
        end
        check(tag, hit, 1'b1);
    endtask

    initial begin
        model_reset();
        // 1: request already pending across reset release
        en = 1'b1; req = 2'b01; data_in = {32'h5566_7788, 32'h1122_3344};
        #12;
        apply_reset(2);
        repeat (12) cycle();
        // 2: both requesting continuously
        req = 2'b11;
        repeat (22) cycle();
        req = 2'b00;
        repeat (6) cycle();
        // 3: requester 1 alone, drops after ack
        data_in = {32'hA1B2_C3D4, 32'h0F0F_0F0F};
        req = 2'b10;
        wait_slot(1, "t3_ack");
        req = 2'b00;
        repeat (7) cycle();
        // 4: en drops in the second STREAM cycle with a request pending
        req = 2'b01;
        wait_slot(3, "t4_stream2");
        en = 1'b0; req = 2'b10;
        repeat (8) cycle();
        en = 1'b1;
        repeat (8) cycle();
        // 5: reset in the third STREAM cycle
        req = 2'b01;
        wait_slot(4, "t5_stream3");
        apply_reset(1);
        repeat (10) cycle();
        // 6: requester 1 arrives while requester 0 streams
        wait_slot(2, "t6_stream0");
        req = 2'b10;
        repeat (8) cycle();
        req = 2'b00;
        repeat (4) cycle();
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            req     = 2'($urandom_range(0, 3));
            data_in = {$urandom, $urandom};
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
